iot_ahb_sram_ctrl: RTL

AHB-Lite slave controller connecting the IoT subsystem bus matrix to a single-port synchronous SRAM macro (one-cycle read latency). It gives zero-wait-state reads and writes by committing write data in its data phase, and by parking write data in a one-entry write buffer when a read address phase claims the SRAM port. Reads merge buffered bytes so read-after-write is always coherent. Unaligned, oversize and out-of-range accesses get a two-cycle ERROR response.

---
 rtl/iot_ahb_sram_ctrl_if.sv | 31 +++
 rtl/iot_ahb_sram_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/iot_ahb_sram_ctrl_if.sv
// AHB-Lite slave port plus single-port SRAM macro port for iot_ahb_sram_ctrl.
// Handshake: a transfer is taken when HSEL & HREADY & HTRANS[1]; the data phase completes on the edge where HREADYOUT=1.
interface iot_ahb_sram_ctrl_if #(
    parameter int AW = 16
);
    logic          HSEL;
    logic          HREADY;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic          HWRITE;
    logic [AW-1:0] HADDR;
    logic [31:0]   HWDATA;
    logic [31:0]   HRDATA;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   SRAMRDATA;
    logic [AW-3:0] SRAMADDR;
    logic [31:0]   SRAMWDATA;
    logic [3:0]    SRAMWEN;
    logic          SRAMCS;

    modport slave (
        input  HSEL, HREADY, HTRANS, HSIZE, HWRITE, HADDR, HWDATA, SRAMRDATA,
        output HRDATA, HREADYOUT, HRESP, SRAMADDR, SRAMWDATA, SRAMWEN, SRAMCS
    );

    modport master (
        output HSEL, HREADY, HTRANS, HSIZE, HWRITE, HADDR, HWDATA, SRAMRDATA,
        input  HRDATA, HREADYOUT, HRESP, SRAMADDR, SRAMWDATA, SRAMWEN, SRAMCS
    );
endinterface

// File: rtl/iot_ahb_sram_ctrl.sv
// Zero-wait-state AHB-Lite to single-port SRAM controller with a one-entry write buffer
// that parks write data whenever a read address phase claims the SRAM port.
module iot_ahb_sram_ctrl #(
    parameter int AW        = 16,
    parameter int MEM_WORDS = 2 ** (AW - 2)
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    iot_ahb_sram_ctrl_if.slave    bus,
    output logic [2:0]            dbg_state,
    output logic                  dbg_buf_full
);

    localparam int WW = AW - 2;
    localparam logic [WW:0] WORD_LIMIT = MEM_WORDS[WW:0];

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    state_t          state;
    logic            hreadyout_q;
    logic            hresp_q;
    logic [WW-1:0]   addr_q;
    logic [3:0]      mask_q;
    logic            buf_full;
    logic [WW-1:0]   buf_addr;
    logic [3:0]      buf_mask;
    logic [31:0]     buf_data;

    logic            accept;
    logic [WW-1:0]   word_idx;
    logic [3:0]      req_mask;
    logic            req_err;
    logic            rd_ap;
    logic            wr_dp;
    logic            unused_htrans0;

    assign unused_htrans0 = bus.HTRANS[0];
    assign accept   = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    assign word_idx = bus.HADDR[AW-1:2];

    always_comb begin
        req_mask = 4'b1111;
        case (bus.HSIZE)
            3'd0:    req_mask = 4'b0001 << bus.HADDR[1:0];
            3'd1:    req_mask = bus.HADDR[1] ? 4'b1100 : 4'b0011;
            default: req_mask = 4'b1111;
        endcase
    end

    assign req_err = (bus.HSIZE > 3'd2)
                   | ((bus.HSIZE == 3'd1) & bus.HADDR[0])
                   | ((bus.HSIZE == 3'd2) & (bus.HADDR[1:0] != 2'b00))
                   | ({1'b0, word_idx} >= WORD_LIMIT);

    assign rd_ap = accept & ~bus.HWRITE & ~req_err;
    assign wr_dp = (state == S_WR);

    // Port priority: read address phase, then direct write, then buffer drain.
    always_comb begin
        bus.SRAMCS    = 1'b0;
        bus.SRAMWEN   = 4'b0000;
        bus.SRAMADDR  = '0;
        bus.SRAMWDATA = '0;
        if (HRESETn) begin
            if (rd_ap) begin
                bus.SRAMCS   = 1'b1;
                bus.SRAMADDR = word_idx;
            end else if (wr_dp) begin
                bus.SRAMCS    = 1'b1;
                bus.SRAMWEN   = mask_q;
                bus.SRAMADDR  = addr_q;
                bus.SRAMWDATA = bus.HWDATA;
            end else if (buf_full) begin
                bus.SRAMCS    = 1'b1;
                bus.SRAMWEN   = buf_mask;
                bus.SRAMADDR  = buf_addr;
                bus.SRAMWDATA = buf_data;
            end
        end
    end

    // Buffered bytes override stale SRAM lanes so read-after-write stays coherent.
    always_comb begin
        bus.HRDATA = '0;
        if (state == S_RD) begin
            for (int i = 0; i < 4; i++) begin
                if (buf_full && (buf_addr == addr_q) && buf_mask[i])
                    bus.HRDATA[8*i +: 8] = buf_data[8*i +: 8];
                else
                    bus.HRDATA[8*i +: 8] = bus.SRAMRDATA[8*i +: 8];
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state       <= S_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            addr_q      <= '0;
            mask_q      <= 4'b0000;
        end else if (state == S_ERR1) begin
            state       <= S_ERR2;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b1;
        end else if (accept) begin
            addr_q <= word_idx;
            mask_q <= req_mask;
            if (req_err) begin
                state       <= S_ERR1;
                hreadyout_q <= 1'b0;
                hresp_q     <= 1'b1;
            end else begin
                state       <= bus.HWRITE ? S_WR : S_RD;
                hreadyout_q <= 1'b1;
                hresp_q     <= 1'b0;
            end
        end else begin
            state       <= S_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            buf_full <= 1'b0;
            buf_addr <= '0;
            buf_mask <= 4'b0000;
            buf_data <= '0;
        end else if (wr_dp && rd_ap) begin
            buf_full <= 1'b1;
            buf_addr <= addr_q;
            buf_mask <= mask_q;
            buf_data <= bus.HWDATA;
        end else if (!rd_ap && !wr_dp && buf_full) begin
            buf_full <= 1'b0;
        end
    end

    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = hresp_q;
    assign dbg_state     = state;
    assign dbg_buf_full  = buf_full;

endmodule
